// File: rtl/bram_bist_pkg.sv
// bram_bist_pkg: FSM state type, error counter width and the BIST test pattern.
package bram_bist_pkg;
  typedef enum logic [2:0] {IDLE, WR, RD, DRAIN, DONE} state_t;
  localparam int ERR_W = 16;
  localparam int MAX_D = 64;
  // The address is widened before +1, so the last address yields N rather than wrapping to 0.
  function automatic logic [MAX_D-1:0] pat(input logic [MAX_D-1:0] a, input logic ph, input int unsigned d_wid);
    pat = ((a + 1'b1) ^ {MAX_D{ph}}) & ((MAX_D'(1) << d_wid) - 1'b1);
  endfunction
endpackage

// File: rtl/bram_bist_if.sv
// bram_bist_if: BRAM write/read port bundle.
// master (BIST side) drives wr_en/wr_addr/wr_data, rd_en/reg_en/rd_addr and samples rd_data.
// slave (BRAM side) takes the reverse directions.
interface bram_bist_if #(parameter int A_WID = 9, D_WID = 32);
  logic wr_en, rd_en, reg_en;
  logic [A_WID-1:0] wr_addr, rd_addr;
  logic [D_WID-1:0] wr_data, rd_data;
  modport master(output wr_en, wr_addr, wr_data, rd_en, reg_en, rd_addr, input rd_data);
  modport slave(input wr_en, wr_addr, wr_data, rd_en, reg_en, rd_addr, output rd_data);
endinterface

// File: rtl/bram_bist_pipe.sv
// bram_bist_pipe: RD_LAT-deep delay line of {valid, addr, expected}, aligned with BRAM read data.
// Ports: clk, rst_n (async, active low); i_v/i_addr/i_exp enter; o_v/o_addr/o_exp leave RD_LAT cycles later.
module bram_bist_pipe #(parameter int A_WID = 9, D_WID = 32, RD_LAT = 1) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_v,
  input  logic [A_WID-1:0] i_addr,
  input  logic [D_WID-1:0] i_exp,
  output logic             o_v,
  output logic [A_WID-1:0] o_addr,
  output logic [D_WID-1:0] o_exp
);
  logic [RD_LAT-1:0] r_v;
  logic [A_WID-1:0] r_addr [RD_LAT];
  logic [D_WID-1:0] r_exp [RD_LAT];
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_v <= '0;
      for (int k = 0; k < RD_LAT; k++) begin
        r_addr[k] <= '0;
        r_exp[k] <= '0;
      end
    end else begin
      r_v[0] <= i_v;
      r_addr[0] <= i_addr;
      r_exp[0] <= i_exp;
      for (int k = 1; k < RD_LAT; k++) begin
        r_v[k] <= r_v[k-1];
        r_addr[k] <= r_addr[k-1];
        r_exp[k] <= r_exp[k-1];
      end
    end
  end
  assign o_v = r_v[RD_LAT-1];
  assign o_addr = r_addr[RD_LAT-1];
  assign o_exp = r_exp[RD_LAT-1];
endmodule

// File: rtl/bram_bist.sv
// bram_bist: two-pass (pattern, inverted pattern) write/read-back BIST engine for a BRAM.
// Ports: clk, rst_n (async, active low); i_start one-cycle request; m_bram BRAM port bundle;
// o_busy, o_done (level), o_pass/o_fail (valid with o_done), o_err_cnt (saturating), o_err_addr (first mismatch).
module bram_bist import bram_bist_pkg::*; #(
  parameter int ID = 0,
  parameter int A_WID = 9,
  parameter int D_WID = 32,
  parameter int RD_LAT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_start,
  bram_bist_if.master      m_bram,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_pass,
  output logic             o_fail,
  output logic [ERR_W-1:0] o_err_cnt,
  output logic [A_WID-1:0] o_err_addr
);
  if (RD_LAT < 1 || RD_LAT > 2 || D_WID < A_WID + 1 || D_WID > MAX_D || ID < 0) begin : g_bad
    $error("bram_bist: illegal parameters");
  end
  localparam logic [A_WID-1:0] LAST = '1;
  localparam logic [A_WID-1:0] DLAST = A_WID'(RD_LAT - 1);
  state_t r_state, w_nxt;
  logic [A_WID-1:0] r_cnt, r_mis_addr, r_err_addr, w_paddr;
  logic [ERR_W-1:0] r_err_cnt;
  logic [D_WID-1:0] w_pat, w_pexp;
  logic r_p, r_done, r_mis, w_start, w_last, w_run, w_pv, w_mis;
  assign w_start = i_start && (r_state == IDLE || r_state == DONE);
  assign w_run = r_state inside {WR, RD, DRAIN};
  assign w_last = r_cnt == (r_state == DRAIN ? DLAST : LAST);
  assign w_pat = D_WID'(pat(MAX_D'(r_cnt), r_p, D_WID));
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else r_state <= w_nxt;
  end
  always_comb begin
    w_nxt = w_start ? WR : !w_last ? r_state :
            r_state == WR ? RD : r_state == RD ? DRAIN :
            r_state == DRAIN ? (r_p ? DONE : WR) : r_state;
  end
  // busy stays up through the first DONE cycle, while the last mismatch is still being accumulated.
  always_comb begin
    m_bram.wr_en = r_state == WR;
    m_bram.wr_addr = r_state == WR ? r_cnt : '0;
    m_bram.wr_data = r_state == WR ? w_pat : '0;
    m_bram.rd_en = r_state == RD;
    m_bram.rd_addr = r_state == RD ? r_cnt : '0;
    m_bram.reg_en = RD_LAT == 2;
    o_busy = w_run || (r_state == DONE && !r_done);
    o_done = r_done;
    o_pass = r_done && r_err_cnt == '0;
    o_fail = r_done && r_err_cnt != '0;
    o_err_cnt = r_err_cnt;
    o_err_addr = r_err_addr;
  end
  bram_bist_pipe #(.A_WID(A_WID), .D_WID(D_WID), .RD_LAT(RD_LAT)) u_pipe (
    .clk(clk), .rst_n(rst_n), .i_v(r_state == RD), .i_addr(r_cnt), .i_exp(w_pat),
    .o_v(w_pv), .o_addr(w_paddr), .o_exp(w_pexp)
  );
  assign w_mis = w_pv && (r_state == RD || r_state == DRAIN) && m_bram.rd_data != w_pexp;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
      r_p <= 1'b0;
      r_done <= 1'b0;
      r_mis <= 1'b0;
      r_mis_addr <= '0;
      r_err_cnt <= '0;
      r_err_addr <= '0;
    end else begin
      r_cnt <= w_run && !w_last ? r_cnt + 1'b1 : '0;
      r_p <= w_start ? 1'b0 : (r_state == DRAIN && w_last) ? 1'b1 : r_p;
      r_done <= r_state == DONE && !w_start;
      r_mis <= w_mis;
      r_mis_addr <= w_paddr;
      if (w_start) begin
        r_err_cnt <= '0;
        r_err_addr <= '0;
      end else if (r_mis) begin
        r_err_cnt <= r_err_cnt + ERR_W'(r_err_cnt != '1);
        if (r_err_cnt == '0) r_err_addr <= r_mis_addr;
      end
    end
  end
endmodule

// File: tb/tb_bram_bist.sv
// tb_bram_bist: self-checking bench; two BISTs (RD_LAT 1 and 2) against BRAM models with injectable faults.
module tb_bram_bist;
  localparam int A_WID = 9;
  localparam int D_WID = 32;
  localparam int N = 1 << A_WID;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  always #5 clk = ~clk;
  int checks = 0;
  int errors = 0;
  int mode = 0;
  int fa = 0;
  int fb = 0;
  int sv = 0;
  int dn [2];
  logic busy [2], done [2], pass [2], fail [2];
  logic [15:0] err_cnt [2];
  logic [A_WID-1:0] err_addr [2];
  logic wr_en_m [2], rd_en_m [2], reg_en_m [2];
  logic [A_WID-1:0] wa_m [2], ra_m [2];
  logic [D_WID-1:0] wd_m [2];
  int wcnt [2];
  int wbad [2];
  logic [D_WID-1:0] w511 [2][2];
  // fault injected on the BRAM read path: 0 good, 1 bit3 stuck-1 at 0x1F, 2 reads 0, 3 random stuck bit
  function automatic logic [D_WID-1:0] flt(input int a, input logic [D_WID-1:0] d);
    logic [D_WID-1:0] m;
    m = D_WID'(1) << fb;
    case (mode)
      1: return a == 31 ? d | 32'h8 : d;
      2: return '0;
      3: return a != fa ? d : (sv != 0 ? d | m : d & ~m);
      default: return d;
    endcase
  endfunction
  for (genvar g = 0; g < 2; g++) begin : g_dut
    bram_bist_if #(.A_WID(A_WID), .D_WID(D_WID)) bus ();
    logic [D_WID-1:0] mem [N];
    logic [D_WID-1:0] q1, q2;
    bram_bist #(.ID(g), .A_WID(A_WID), .D_WID(D_WID), .RD_LAT(g + 1)) dut (
      .clk(clk), .rst_n(rst_n), .i_start(start), .m_bram(bus),
      .o_busy(busy[g]), .o_done(done[g]), .o_pass(pass[g]), .o_fail(fail[g]),
      .o_err_cnt(err_cnt[g]), .o_err_addr(err_addr[g])
    );
    assign bus.rd_data = g == 0 ? q1 : q2;
    assign wr_en_m[g] = bus.wr_en;
    assign rd_en_m[g] = bus.rd_en;
    assign reg_en_m[g] = bus.reg_en;
    assign wa_m[g] = bus.wr_addr;
    assign ra_m[g] = bus.rd_addr;
    assign wd_m[g] = bus.wr_data;
    always @(posedge clk) begin
      if (bus.wr_en) begin
        mem[bus.wr_addr] <= bus.wr_data;
        wcnt[g] <= wcnt[g] + 1;
        if (bus.wr_data != D_WID'(bus.wr_addr) + 1 && bus.wr_data != ~(D_WID'(bus.wr_addr) + 1))
          wbad[g] <= wbad[g] + 1;
        if (&bus.wr_addr) begin
          w511[g][0] <= w511[g][1];
          w511[g][1] <= bus.wr_data;
        end
      end
      if (bus.rd_en) q1 <= flt(int'(bus.rd_addr), mem[bus.rd_addr]);
      if (bus.reg_en) q2 <= q1;
    end
  end
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got 0x%0h want 0x%0h", tag, got, want);
    end
  endtask
  // expected result straight from the test rules: two passes, compare every address, saturate, first failing address
  task automatic model(output int ec, output int ea);
    logic [D_WID-1:0] e;
    ec = 0;
    ea = 0;
    for (int p = 0; p < 2; p++)
      for (int a = 0; a < N; a++) begin
        e = D_WID'(a + 1);
        if (p == 1) e = ~e;
        if (flt(a, e) != e) begin
          if (ec == 0) ea = a;
          if (ec < 65535) ec++;
        end
      end
  endtask
  task automatic chk_idle(input string tag);
    for (int g = 0; g < 2; g++) begin
      chk({tag, "_busy"}, busy[g], 0);
      chk({tag, "_done"}, done[g], 0);
      chk({tag, "_pass"}, pass[g], 0);
      chk({tag, "_fail"}, fail[g], 0);
      chk({tag, "_err_cnt"}, err_cnt[g], 0);
      chk({tag, "_err_addr"}, err_addr[g], 0);
      chk({tag, "_wr_en"}, wr_en_m[g], 0);
      chk({tag, "_rd_en"}, rd_en_m[g], 0);
      chk({tag, "_wr_addr"}, wa_m[g], 0);
      chk({tag, "_rd_addr"}, ra_m[g], 0);
      chk({tag, "_wr_data"}, wd_m[g], 0);
      chk({tag, "_reg_en"}, reg_en_m[g], g == 1);
    end
  endtask
  // extra: edge count after which a second start pulse is offered (0 = none)
  task automatic run(input int extra);
    dn[0] = 0;
    dn[1] = 0;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    chk("busy_after_start", busy[0] & busy[1], 1);
    chk("done_cleared", done[0] | done[1], 0);
    chk("err_cleared", err_cnt[0] | err_cnt[1], 0);
    for (int c = 1; c <= 5000 && (dn[0] == 0 || dn[1] == 0); c++) begin
      @(posedge clk);
      #1 start = c == extra;
      for (int g = 0; g < 2; g++) if (done[g] && dn[g] == 0) dn[g] = c;
    end
    start = 1'b0;
  endtask
  task automatic full(input int extra);
    int w0 [2];
    int b0 [2];
    int ec, ea;
    w0 = wcnt;
    b0 = wbad;
    run(extra);
    model(ec, ea);
    for (int g = 0; g < 2; g++) begin
      chk($sformatf("done_edge%0d", g), dn[g], 2 * (2 * N + g + 1) + 1);
      chk($sformatf("busy_end%0d", g), busy[g], 0);
      chk($sformatf("pass%0d", g), pass[g], ec == 0);
      chk($sformatf("fail%0d", g), fail[g], ec != 0);
      chk($sformatf("err_cnt%0d", g), err_cnt[g], ec);
      chk($sformatf("err_addr%0d", g), err_addr[g], ea);
      chk($sformatf("wr_count%0d", g), wcnt[g] - w0[g], 2 * N);
      chk($sformatf("wr_bad%0d", g), wbad[g] - b0[g], 0);
      chk($sformatf("w511_p0_%0d", g), w511[g][0], 32'h0000_0200);
      chk($sformatf("w511_p1_%0d", g), w511[g][1], 32'hFFFF_FDFF);
    end
  endtask
  initial begin
    repeat (3) @(posedge clk);
    #1 chk_idle("reset");
    @(negedge clk);
    rst_n = 1'b1;
    mode = 0;
    full(0);
    mode = 1;
    full(0);
    mode = 2;
    full(0);
    repeat (3) begin
      mode = 3;
      fa = $urandom_range(0, N - 1);
      fb = $urandom_range(0, 31);
      sv = $urandom_range(0, 1);
      full($urandom_range(1, 2000));
    end
    mode = 0;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (700) @(posedge clk);
    #1 rst_n = 1'b0;
    #1 chk_idle("midrun_reset");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    full(0);
    full(99);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
